// File: rtl/quad_pkg.sv
// Purpose: shared types and constants for the quadrature decoder.
// Latency: n/a, declarations only.
// Backpressure: n/a, declarations only.
//
// Contents: FSM state enum, Gray phase codes, synchronizer fill count,
// step classification result type and a forward-phase helper.
package quad_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Gray-coded phases in forward order {A,B}: 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  // Edges spent in INIT before ab_prev is loaded
  localparam int INIT_CYCLES = 2;

  typedef enum logic [1:0] {
    CL_NONE = 2'd0,
    CL_FWD  = 2'd1,
    CL_REV  = 2'd2,
    CL_ILL  = 2'd3
  } step_t;

  // Phase that follows ph when moving forward
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH0:     nxt = PH1;
      PH1:     nxt = PH2;
      PH2:     nxt = PH3;
      default: nxt = PH0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clk edges from a stable input to q.
// Backpressure: none, free-running.
//
// Ports: clk, rst_n (async active-low, clears both stages to 0),
//        d (async input bus), q (synchronized output bus).
module sync_2ff #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Purpose: decodes quadrature A/B into STEP/UP events and a wrapping position Q.
// Latency: a pin change stable before edge k is reflected in Q/UP/STEP at edge k+2.
// Backpressure: none; pins may change at most once per CK cycle, faster input flags ERR.
//
// Ports: CK clock, R async active-low reset, A/B async phases, CLR sync clear
//        of Q and ERR; Q position, UP last direction, STEP one-cycle step
//        pulse, ERR sticky illegal-transition flag.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         CK,
  input  logic         R,
  input  logic         A,
  input  logic         B,
  input  logic         CLR,
  output logic [W-1:0] Q,
  output logic         UP,
  output logic         STEP,
  output logic         ERR
);

  logic [1:0] ab_sync;
  logic [1:0] ab_prev;
  logic [1:0] init_cnt;
  state_t     state;
  step_t      cls;

  sync_2ff #(
    .WIDTH(2)
  ) u_sync (
    .clk  (CK),
    .rst_n(R),
    .d    ({A, B}),
    .q    (ab_sync)
  );

  // Both bits flipping is neither neighbour in the Gray cycle
  function automatic step_t classify(input logic [1:0] prev, input logic [1:0] cur);
    step_t res;
    if (cur == prev)                  res = CL_NONE;
    else if (cur == next_phase(prev)) res = CL_FWD;
    else if (prev == next_phase(cur)) res = CL_REV;
    else                              res = CL_ILL;
    return res;
  endfunction

  assign cls = classify(ab_prev, ab_sync);

  always_ff @(posedge CK or negedge R) begin
    if (!R) begin
      state    <= INIT;
      init_cnt <= 2'd0;
      ab_prev  <= 2'b00;
      Q        <= '0;
      UP       <= 1'b1;
      STEP     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      STEP <= 1'b0;
      case (state)
        INIT: begin
          // Wait for the synchronizer to hold real pin levels, then
          // adopt them as the reference without counting anything.
          if (init_cnt == 2'(INIT_CYCLES)) begin
            ab_prev <= ab_sync;
            state   <= TRACK;
          end else begin
            init_cnt <= init_cnt + 2'd1;
          end
        end
        TRACK: begin
          // Reference always follows the pins, even under CLR, so a
          // discarded step is neither lost nor counted twice later.
          ab_prev <= ab_sync;
          if (!CLR) begin
            case (cls)
              CL_FWD: begin
                Q    <= Q + W'(1);
                UP   <= 1'b1;
                STEP <= 1'b1;
              end
              CL_REV: begin
                Q    <= Q - W'(1);
                UP   <= 1'b0;
                STEP <= 1'b1;
              end
              CL_ILL:  ERR <= 1'b1;
              default: ;
            endcase
          end
        end
        default: state <= INIT;
      endcase
      if (CLR) begin
        Q   <= '0;
        ERR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
module tb_quadrature_decoder;
  import quad_pkg::*;

  localparam int W = 3;

  logic         CK;
  logic         R;
  logic         A;
  logic         B;
  logic         CLR;
  logic [W-1:0] Q;
  logic         UP;
  logic         STEP;
  logic         ERR;

  int checks   = 0;
  int failures = 0;

  quadrature_decoder #(
    .W(W)
  ) dut (
    .CK  (CK),
    .R   (R),
    .A   (A),
    .B   (B),
    .CLR (CLR),
    .Q   (Q),
    .UP  (UP),
    .STEP(STEP),
    .ERR (ERR)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one pin change and follow it through the 2-edge pipeline:
  // no pulse one edge early, one pulse with new Q/UP, then pulse gone.
  task automatic step(input logic [1:0] ab, input logic [W-1:0] q_exp,
                      input logic up_exp, input string tag);
    {A, B} = ab;
    tick();
    tick();
    chk({tag, "_step_early"}, 32'(STEP), 32'd0);
    tick();
    chk({tag, "_step"}, 32'(STEP), 32'd1);
    chk({tag, "_q"}, 32'(Q), 32'(q_exp));
    chk({tag, "_up"}, 32'(UP), 32'(up_exp));
    tick();
    chk({tag, "_step_gone"}, 32'(STEP), 32'd0);
  endtask

  task automatic clr_pulse();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
  endtask

  initial begin
    // 1: pins at 11 through reset, no false step or error after INIT
    R = 1'b1; A = 1'b1; B = 1'b1; CLR = 1'b0;
    #1 R = 1'b0;
    #1;
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_up", 32'(UP), 32'd1);
    chk("rst_step", 32'(STEP), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    tick();
    tick();
    R = 1'b1;
    tick();
    tick();
    chk("init_after_e2", 32'(int'(dut.state)), 32'(int'(INIT)));
    tick();
    chk("track_after_e3", 32'(int'(dut.state)), 32'(int'(TRACK)));
    tick();
    tick();
    chk("init11_q", 32'(Q), 32'd0);
    chk("init11_step", 32'(STEP), 32'd0);
    chk("init11_err", 32'(ERR), 32'd0);

    // Walk to 00 and clear so the forward run starts from Q=0
    step(2'b10, 3'd1, 1'b1, "pre_a");
    step(2'b00, 3'd2, 1'b1, "pre_b");
    clr_pulse();
    chk("pre_clr_q", 32'(Q), 32'd0);

    // 2: forward cycle 00->01->11->10->00
    step(2'b01, 3'd1, 1'b1, "fwd1");
    step(2'b11, 3'd2, 1'b1, "fwd2");
    step(2'b10, 3'd3, 1'b1, "fwd3");
    step(2'b00, 3'd4, 1'b1, "fwd4");

    // 3: wrap forward 7->0, then reverse 0->7->6
    step(2'b01, 3'd5, 1'b1, "fwd5");
    step(2'b11, 3'd6, 1'b1, "fwd6");
    step(2'b10, 3'd7, 1'b1, "fwd7");
    step(2'b00, 3'd0, 1'b1, "wrap_up");
    step(2'b10, 3'd7, 1'b0, "wrap_dn");
    step(2'b11, 3'd6, 1'b0, "rev2");

    // 4: illegal 11->00 sets sticky ERR, Q/UP hold, no pulse
    {A, B} = 2'b00;
    tick();
    tick();
    tick();
    chk("ill_err", 32'(ERR), 32'd1);
    chk("ill_q", 32'(Q), 32'd6);
    chk("ill_step", 32'(STEP), 32'd0);
    chk("ill_up", 32'(UP), 32'd0);
    tick();
    step(2'b01, 3'd7, 1'b1, "after_ill");
    chk("err_sticky", 32'(ERR), 32'd1);
    clr_pulse();
    chk("clr_err", 32'(ERR), 32'd0);
    chk("clr_q", 32'(Q), 32'd0);

    // 5: CLR on the classifying edge of a forward step discards it
    {A, B} = 2'b11;
    tick();
    tick();
    clr_pulse();
    chk("clrstep_q", 32'(Q), 32'd0);
    chk("clrstep_step", 32'(STEP), 32'd0);
    chk("clrstep_up", 32'(UP), 32'd1);
    tick();
    chk("clrstep_q_later", 32'(Q), 32'd0);
    step(2'b10, 3'd1, 1'b1, "no_dbl");

    // CLR beats a simultaneous illegal transition 10->01
    {A, B} = 2'b01;
    tick();
    tick();
    clr_pulse();
    chk("clrill_err", 32'(ERR), 32'd0);
    chk("clrill_q", 32'(Q), 32'd0);
    chk("clrill_step", 32'(STEP), 32'd0);
    tick();
    step(2'b11, 3'd1, 1'b1, "post_clrill");
    chk("post_clrill_err", 32'(ERR), 32'd0);

    // 6: async reset between edges while STEP is high
    step(2'b01, 3'd0, 1'b0, "rev_a");
    step(2'b00, 3'd7, 1'b0, "rev_b");
    {A, B} = 2'b10;
    tick();
    tick();
    tick();
    chk("prerst_step", 32'(STEP), 32'd1);
    chk("prerst_q", 32'(Q), 32'd6);
    chk("prerst_up", 32'(UP), 32'd0);
    #2 R = 1'b0;
    #1;
    chk("arst_q", 32'(Q), 32'd0);
    chk("arst_up", 32'(UP), 32'd1);
    chk("arst_step", 32'(STEP), 32'd0);
    chk("arst_err", 32'(ERR), 32'd0);
    tick();
    chk("arst_hold_q", 32'(Q), 32'd0);
    R = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("reinit_q", 32'(Q), 32'd0);
    chk("reinit_step", 32'(STEP), 32'd0);
    chk("reinit_err", 32'(ERR), 32'd0);
    step(2'b00, 3'd1, 1'b1, "recount");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Decodes a 2-phase quadrature (Gray-coded) signal pair A/B into direction and step events, and accumulates a W-bit position count.
- It is the decode end of the up/down counting interface. Its UP output and STEP pulse drive an up/down counter directly.
- It also carries its own wrap-around position register Q.
- Sits between asynchronous encoder pins and synchronous counting/control logic.

Parameters:
- W, 3, width of position counter Q (modular, wraps).

Ports:
- CK  input  1  clock; all state updates on posedge CK.
- R  input  1  reset, asynchronous, active-low; R=0 forces reset state immediately.
- A  input  1  quadrature phase A, asynchronous to CK.
- B  input  1  quadrature phase B, asynchronous to CK.
- CLR  input  1  synchronous clear of Q and ERR, active-high.
- Q  output  W  current position count.
- UP  output  1  direction of last valid step (1=forward/up, 0=reverse/down).
- STEP  output  1  one-cycle pulse per valid quadrature step.
- ERR  output  1  sticky illegal-transition flag.

Behaviour:
- Reset (R=0, async), all of the following:
  - sync regs=00, ab_prev=00.
  - state=INIT, init count=0.
  - Q=0, UP=1, STEP=0, ERR=0.
- Synchronizer: A and B each pass through 2 flops (a1→a2, b1→b2); only a2/b2 are used.
- Latency: an input change stable before edge k appears in a2/b2 after edge k+1. Q/UP/STEP update at edge k+2.
- FSM states:
  - INIT: counts 2 edges after reset release while synchronizers fill. On the 3rd edge it loads ab_prev←{a2,b2} with no count, STEP or ERR, then goes to TRACK. This prevents a false step/error when the pins are not 00 at reset.
  - TRACK: every edge, ab_prev←{a2,b2} and cur={a2,b2} is classified against ab_prev.
- Classification, forward sequence AB: 00→01→11→10→00.
  - Forward step: Q←Q+1 mod 2^W, UP←1, STEP←1.
  - Reverse step (10→11→01→00→10): Q←Q-1 mod 2^W, UP←0, STEP←1.
  - No change: Q, UP hold; STEP←0.
  - Double change (00↔11, 01↔10): ERR←1 (sticky); Q, UP hold; STEP←0.
- Wrap-around:
  - Q=2^W-1 plus forward → 0.
  - Q=0 plus reverse → 2^W-1.
  - No saturation or overflow flag.
- CLR=1 (any state):
  - Q←0, ERR←0 at that edge.
  - A simultaneous step is discarded: STEP←0, UP holds.
  - ab_prev still updates, so no step is lost or double-counted later.
  - CLR has priority over a simultaneous illegal transition: ERR ends 0.
- STEP is high for exactly one cycle per valid transition. Back-to-back steps on consecutive edges give consecutive STEP pulses.
- Reset mid-operation: the async return to INIT discards any pending transition. The count restarts at 0 after the INIT sequence.
- Inputs must not change more than once per CK cycle. Faster input is outside the guaranteed range and is reported as ERR when detected.

Decomposition:
- Shared package quad_pkg holds:
  - FSM state enum (INIT, TRACK).
  - Phase encoding constants PH0=2'b00, PH1=2'b01, PH2=2'b11, PH3=2'b10.
  - INIT_CYCLES=2.
- One sub-module: sync_2ff (parameterised width, async active-low reset to 0), instanced once with width 2 for {A,B}.
- Step classification stays as a combinational function in quadrature_decoder.

Test Plan:
1. Hold A=B=1 through reset, release R -> no STEP, ERR=0, Q=0 after INIT; 3rd edge leaves INIT.
2. Forward sequence 00→01→11→10→00, each held 4 cycles, W=3 -> Q=1,2,3,4; UP=1; four single-cycle STEP pulses, each 2 edges after its input change.
3. From Q=7, apply 1 forward step -> Q=0. Then 2 reverse steps -> Q=7, then 6; UP=0.
4. Jump AB 00→11 -> ERR=1, Q unchanged, STEP=0. ERR stays 1 over later valid steps until CLR=1, which sets ERR=0, Q=0.
5. Assert CLR on the same edge a forward step is classified -> Q=0, STEP=0. The next valid step gives Q=1, proving no double count.
6. Drive R=0 mid-sequence between clock edges -> Q=0, UP=1, STEP=0 immediately, without waiting for an edge. Recount resumes from 0 after INIT.
